apb_reg_slave: RTL
==================

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: APB data width; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: paddr width in word-index units.
REQ-003 SHALL have parameter NUM_PAYLOAD, default 2: number of payload registers.
REQ-004 SHALL have parameter ERR_STATUS_ADDRESS, default 1: word address of the read-only error status register.
REQ-005 SHALL have parameter PAYLOAD_ADDRESS, default 2: word address of payload[0]; payload[i] is at PAYLOAD_ADDRESS+i.
REQ-006 SHALL have parameter DATA_SIZE_ADDRESS, default 4: word address of the data size register; it lies outside the payload range.
REQ-007 SHALL have parameter WAIT_STATES, default 0: number of pready-low ACCESS cycles inserted per transfer.
REQ-008 SHALL have port pclk, input, 1 bit: clock, rising edge.
REQ-009 SHALL have port presetn, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have ports psel, penable and pwrite, inputs, 1 bit each: APB control.
REQ-011 SHALL have port paddr, input, ADDR_WIDTH bits: word address.
REQ-012 SHALL have port pwdata, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port pstrb, input, DATA_WIDTH/8 bits: byte write strobes.
REQ-014 SHALL have port prdata, output, DATA_WIDTH bits: read data.
REQ-015 SHALL have port pready, output, 1 bit: transfer complete.
REQ-016 SHALL have port pslverr, output, 1 bit: transfer error; valid only with pready.
REQ-017 SHALL have port payload_out, output, NUM_PAYLOAD*DATA_WIDTH bits: payload registers concatenated, payload[0] in the LSBs.
REQ-018 SHALL have port data_size_out, output, DATA_WIDTH bits: data size register.
REQ-019 SHALL have port err_status_out, output, 3 bits: sticky error flags.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-021 SHALL transition IDLE->SETUP when psel=1 and penable=0, capturing paddr, pwrite, pwdata and pstrb.
REQ-022 SHALL transition SETUP->ACCESS unconditionally on the next cycle.
REQ-023 SHALL, in ACCESS, hold pready=0 for WAIT_STATES cycles, counted by a wait counter cleared on entry, then drive pready=1 for exactly one cycle (the completion cycle) and return to IDLE.
REQ-024 SHALL give a zero-wait transfer two cycles from setup to completion: SETUP, then ACCESS with pready=1.
REQ-025 SHALL treat psel=0 or penable=0 in any ACCESS cycle before completion as an abort: set err_status[2], make no register update, assert no pready, go to IDLE.
REQ-026 SHALL ignore psel=1 with penable=1 while in IDLE and set err_status[2].
REQ-027 SHALL assert pslverr=1 on completion when writing ERR_STATUS_ADDRESS, and set err_status[0].
REQ-028 SHALL assert pslverr=1 on completion for any address not in {ERR_STATUS_ADDRESS, payload range, DATA_SIZE_ADDRESS}, and set err_status[1].
REQ-029 SHALL assert pslverr=1 on completion for a data size write whose strobed result exceeds NUM_PAYLOAD*DATA_WIDTH/8, leaving the register unchanged and setting err_status[1].
REQ-030 SHALL, on an error-free write completion, update each byte of the target register whose pstrb bit is 1; bytes with pstrb=0 are unchanged.
REQ-031 SHALL, on read completion, drive prdata with the target register; ERR_STATUS reads return {DATA_WIDTH-3 zeros, err_status}.
REQ-032 SHALL drive prdata=0 in all non-completion cycles and on errored reads.
REQ-033 SHALL clear err_status on an error-free ERR_STATUS read completion; flags set in that same cycle survive, with set winning over clear.
REQ-034 SHALL keep err_status flags set until cleared by such a read or by reset.
REQ-035 SHALL update registers and err_status only on the clock edge ending the completion cycle, except for aborts.
REQ-036 SHALL drive payload_out, data_size_out and err_status_out directly from registers.

Reset
REQ-037 SHALL, on presetn=0, immediately force state=IDLE, wait counter=0, all payload registers=0, data size=0 and err_status=0.
REQ-038 SHALL hold pready=0, pslverr=0 and prdata=0 throughout reset.
REQ-039 SHALL make no register update for a transfer in progress when reset asserts, and SHALL require the next transfer to start from IDLE after presetn deasserts.

Verification (DATA_WIDTH=32, NUM_PAYLOAD=2, WAIT_STATES=1)
REQ-040 Write 0xDEADBEEF to addr 2 with pstrb=0xF -> pready high on the 2nd ACCESS cycle, pslverr=0, payload_out[31:0]=0xDEADBEEF; a read of addr 2 returns 0xDEADBEEF.
REQ-041 Write 0x000000AA to addr 3 with pstrb=0x1 over a prior value of 0x11223344 -> register reads 0x112233AA.
REQ-042 Write 8 to addr 4 -> pslverr=0, data_size_out=8; write 9 to addr 4 -> pslverr=1, data_size_out stays 8, err_status[1]=1.
REQ-043 Write to addr 1 -> pslverr=1, err_status=3'b001; read addr 1 -> prdata=1, pslverr=0; read addr 1 again -> prdata=0.
REQ-044 Read addr 7 -> pslverr=1, prdata=0; drop penable mid-ACCESS -> no pready, err_status[2]=1.
REQ-045 Pulse presetn low during ACCESS of a write of 0x55 to addr 2 -> payload_out=0, pready=0; a following write of 0x55 to addr 2 completes normally.

Source files
------------

// File: rtl/apb_reg_slave.sv
// APB register slave: error status, payload array and data size registers.
// Ports: APB slave (pclk, presetn, psel, penable, pwrite, paddr, pwdata,
//   pstrb -> prdata, pready, pslverr); payload_out, data_size_out and
//   err_status_out expose the register contents directly.
module apb_reg_slave #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 3,
  parameter int NUM_PAYLOAD        = 2,
  parameter int ERR_STATUS_ADDRESS = 1,
  parameter int PAYLOAD_ADDRESS    = 2,
  parameter int DATA_SIZE_ADDRESS  = 4,
  parameter int WAIT_STATES        = 0
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [ADDR_WIDTH-1:0]         paddr,
  input  logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [DATA_WIDTH/8-1:0]       pstrb,
  output logic [DATA_WIDTH-1:0]         prdata,
  output logic                          pready,
  output logic                          pslverr,
  output logic [NUM_PAYLOAD*DATA_WIDTH-1:0] payload_out,
  output logic [DATA_WIDTH-1:0]         data_size_out,
  output logic [2:0]                    err_status_out
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [DATA_WIDTH-1:0] MAX_SIZE =
    DATA_WIDTH'(NUM_PAYLOAD * NB);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                          state_q, state_d;
  logic [WW-1:0]                   wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic                            write_q, write_d;
  logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
  logic [NB-1:0]                   strb_q, strb_d;
  logic [NUM_PAYLOAD*DATA_WIDTH-1:0] pay_q, pay_d;
  logic [DATA_WIDTH-1:0]           size_q, size_d;
  logic [2:0]                      err_q, err_d;

  logic [31:0]           a;
  logic                  hit_err, hit_pay, hit_size;
  logic [DATA_WIDTH-1:0] cur, merged;
  logic                  done, clr;
  logic [2:0]            set;

  // Target decode and strobe merge on the captured transfer.
  always_comb begin
    a        = 32'(addr_q);
    hit_err  = (a == 32'(ERR_STATUS_ADDRESS));
    hit_size = (a == 32'(DATA_SIZE_ADDRESS));
    hit_pay  = 1'b0;
    cur      = '0;
    for (int i = 0; i < NUM_PAYLOAD; i++) begin
      if (a == 32'(PAYLOAD_ADDRESS + i)) begin
        hit_pay = 1'b1;
        cur     = pay_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (hit_size) cur = size_q;
    if (hit_err)  cur = DATA_WIDTH'(err_q);
    merged = cur;
    for (int b = 0; b < NB; b++) begin
      if (strb_q[b]) merged[b*8 +: 8] = wdata_q[b*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    pay_d   = pay_q;
    size_d  = size_q;
    set     = 3'b000;
    clr     = 1'b0;
    done    = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          state_d = SETUP;
        end else if (psel && penable) begin
          set[2] = 1'b1;
        end
      end
      SETUP: begin
        wait_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!psel || !penable) begin
          set[2]  = 1'b1;
          state_d = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      pready = 1'b1;
      if (!(hit_err || hit_pay || hit_size)) begin
        pslverr = 1'b1;
        set[1]  = 1'b1;
      end else if (write_q) begin
        if (hit_err) begin
          pslverr = 1'b1;
          set[0]  = 1'b1;
        end else if (hit_size && (merged > MAX_SIZE)) begin
          pslverr = 1'b1;
          set[1]  = 1'b1;
        end else if (hit_size) begin
          size_d = merged;
        end else begin
          for (int i = 0; i < NUM_PAYLOAD; i++) begin
            if (a == 32'(PAYLOAD_ADDRESS + i))
              pay_d[i*DATA_WIDTH +: DATA_WIDTH] = merged;
          end
        end
      end else begin
        prdata = cur;
        clr    = hit_err;
      end
    end

    // New flags win over the read-to-clear.
    err_d = (clr ? 3'b000 : err_q) | set;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      pay_q   <= '0;
      size_q  <= '0;
      err_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      pay_q   <= pay_d;
      size_q  <= size_d;
      err_q   <= err_d;
    end
  end

  assign payload_out    = pay_q;
  assign data_size_out  = size_q;
  assign err_status_out = err_q;

endmodule
